// File: rtl/cordic_upconverter_if.sv
// TX mixer bundle: NCO control, baseband samples, DAC output.
// master drives baseband/NCO, slave is the mixer.
interface cordic_upconverter_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 14
);
    logic signed [31:0]          frequency;
    logic                        freq_load;
    logic                        tx_en;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_I;
    logic signed [IN_WIDTH-1:0]  in_Q;
    logic signed [OUT_WIDTH-1:0] dac_data;
    logic                        out_valid;

    modport master (
        output frequency, freq_load, tx_en,
        output in_valid, in_I, in_Q,
        input  dac_data, out_valid
    );

    modport slave (
        input  frequency, freq_load, tx_en,
        input  in_valid, in_I, in_Q,
        output dac_data, out_valid
    );
endinterface

// File: rtl/cordic_upconverter.sv
// CORDIC upconverter: dac = I*cos(ph) - Q*sin(ph), unrolled
// rotation pipeline fed by a 32-bit NCO and a zero-order hold.
module cordic_upconverter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 14,
    parameter int STG       = 16
) (
    input logic clock,
    input logic reset,
    cordic_upconverter_if.slave bus
);
    localparam int WR  = IN_WIDTH + 2;
    localparam int WZ  = 20;
    localparam int LAT = STG + 2;
    localparam int SH  = WR - OUT_WIDTH;
    localparam int CW  = $clog2(LAT + 1);

    localparam logic signed [WR:0] HALF = (WR+1)'(1 << (SH-1));
    localparam logic signed [WR:0] SMAX = (WR+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [WR:0] SMIN = (WR+1)'(-(2**(OUT_WIDTH-1)));

    // atan(2^-n) scaled so that pi/2 = 2^(WZ-1)
    function automatic logic signed [WZ-1:0] atan_lut(input int n);
        case (n)
            0:       return 20'sd262144;
            1:       return 20'sd154753;
            2:       return 20'sd81767;
            3:       return 20'sd41506;
            4:       return 20'sd20834;
            5:       return 20'sd10427;
            6:       return 20'sd5215;
            7:       return 20'sd2608;
            8:       return 20'sd1304;
            9:       return 20'sd652;
            10:      return 20'sd326;
            11:      return 20'sd163;
            12:      return 20'sd81;
            13:      return 20'sd41;
            14:      return 20'sd20;
            15:      return 20'sd10;
            default: return '0;
        endcase
    endfunction

    logic [31:0]                 phase;
    logic [31:0]                 freq_reg;
    logic signed [IN_WIDTH-1:0]  hold_i;
    logic signed [IN_WIDTH-1:0]  hold_q;

    logic signed [WR-1:0]        ie;
    logic signed [WR-1:0]        qe;
    logic signed [WR-1:0]        x0_d;
    logic signed [WR-1:0]        y0_d;

    logic signed [WR-1:0]        xr [0:STG];
    logic signed [WR-1:0]        yr [0:STG-1];
    logic signed [WZ-1:0]        zr [0:STG-1];

    logic signed [WR:0]          xext;
    logic signed [WR:0]          rnd;
    logic signed [OUT_WIDTH-1:0] sat;
    logic signed [OUT_WIDTH-1:0] dac_q;
    logic [CW-1:0]               fill;

    // Fine phase bits below the CORDIC angle resolution only feed the NCO
    logic unused_phase_lsb;
    assign unused_phase_lsb = ^phase[10:0];

    // NCO accumulator, frequency latch and baseband zero-order hold
    always_ff @(posedge clock) begin
        if (reset) begin
            phase    <= '0;
            freq_reg <= '0;
            hold_i   <= '0;
            hold_q   <= '0;
        end else begin
            phase <= phase + freq_reg;
            if (bus.freq_load)
                freq_reg <= bus.frequency;
            if (bus.in_valid) begin
                hold_i <= bus.in_I;
                hold_q <= bus.in_Q;
            end
        end
    end

    // Widen before the quadrant fold so negating the most negative input is safe
    assign ie = bus.tx_en ? {{(WR-IN_WIDTH){hold_i[IN_WIDTH-1]}}, hold_i} : '0;
    assign qe = bus.tx_en ? {{(WR-IN_WIDTH){hold_q[IN_WIDTH-1]}}, hold_q} : '0;

    // Coarse quadrant rotation so the CORDIC only sees 0..pi/2
    always_comb begin
        x0_d = ie;
        y0_d = qe;
        unique case (phase[31:30])
            2'd0: begin x0_d = ie;  y0_d = qe;  end
            2'd1: begin x0_d = -qe; y0_d = ie;  end
            2'd2: begin x0_d = -ie; y0_d = -qe; end
            2'd3: begin x0_d = qe;  y0_d = -ie; end
        endcase
    end

    // Stage-0 register and the unrolled micro-rotation pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n <= STG; n++)
                xr[n] <= '0;
            for (int n = 0; n < STG; n++) begin
                yr[n] <= '0;
                zr[n] <= '0;
            end
        end else begin
            xr[0] <= x0_d;
            yr[0] <= y0_d;
            zr[0] <= {1'b0, phase[29:11]};
            for (int n = 0; n < STG-1; n++) begin
                if (!zr[n][WZ-1]) begin
                    xr[n+1] <= xr[n] - (yr[n] >>> n);
                    yr[n+1] <= yr[n] + (xr[n] >>> n);
                    zr[n+1] <= zr[n] - atan_lut(n);
                end else begin
                    xr[n+1] <= xr[n] + (yr[n] >>> n);
                    yr[n+1] <= yr[n] - (xr[n] >>> n);
                    zr[n+1] <= zr[n] + atan_lut(n);
                end
            end
            if (!zr[STG-1][WZ-1])
                xr[STG] <= xr[STG-1] - (yr[STG-1] >>> (STG-1));
            else
                xr[STG] <= xr[STG-1] + (yr[STG-1] >>> (STG-1));
        end
    end

    assign xext = {xr[STG][WR-1], xr[STG]};
    assign rnd  = (xext + HALF) >>> SH;

    // Round-half-up result clamped to the DAC code range
    always_comb begin
        sat = rnd[OUT_WIDTH-1:0];
        if (rnd > SMAX)
            sat = SMAX[OUT_WIDTH-1:0];
        else if (rnd < SMIN)
            sat = SMIN[OUT_WIDTH-1:0];
    end

    // DAC output register and pipeline fill counter
    always_ff @(posedge clock) begin
        if (reset) begin
            dac_q <= '0;
            fill  <= '0;
        end else begin
            dac_q <= sat;
            if (fill != CW'(LAT))
                fill <= fill + 1'b1;
        end
    end

    assign bus.dac_data  = dac_q;
    assign bus.out_valid = (fill == CW'(LAT));
endmodule

// File: tb/tb_cordic_upconverter.sv
// Directed bench for cordic_upconverter: reset/fill, DC, fs/4,
// fs/8 full-scale, frequency flip, tx_en gating and zero-order hold.
module tb_cordic_upconverter;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    cordic_upconverter_if bus ();

    cordic_upconverter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_chk++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int dac();
        return int'(bus.dac_data);
    endfunction

    // Reset, then load frequency and sample on edge 1; returns after edge 19,
    // where dac_data reflects phase 0
    task automatic start(input logic [31:0] f, input int i, input int q, input logic en);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        bus.frequency = f;
        bus.freq_load = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_I      = 16'(i);
        bus.in_Q      = 16'(q);
        bus.tx_en     = en;
        tick(1);
        bus.freq_load = 1'b0;
        bus.in_valid  = 1'b0;
        tick(18);
    endtask

    int fs4_i [4]  = '{823, 0, -823, 0};
    int fs4_q [4]  = '{0, -823, 0, 823};
    int fs8 [8]    = '{-3372, 0, 3372, 4769, 3372, 0, -3372, -4769};
    int flip [10]  = '{0, -823, 0, 823, 0, 823, 0, -823, 0, 823};
    int zoh_in [4] = '{16000, -8000, 4000, 0};
    int zoh_ex [4] = '{1647, -823, 412, 0};
    int rise;

    initial begin
        reset         = 1'b1;
        bus.frequency = '0;
        bus.freq_load = 1'b0;
        bus.tx_en     = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_I      = '0;
        bus.in_Q      = '0;
        tick(2);

        // Mid-stream reset and fill timing
        start(32'h4000_0000, 8000, 0, 1'b1);
        tick(5);
        reset = 1'b1;
        tick(3);
        chk("rst_dac", dac(), 0);
        chk("rst_ov", int'(bus.out_valid), 0);
        reset = 1'b0;
        rise = -1;
        for (int e = 1; e <= 30; e++) begin
            tick(1);
            if (bus.out_valid && rise < 0)
                rise = e;
        end
        chk("ov_rise", rise, 18);
        chk("post_rst_dac", dac(), 0);

        // DC, full-ish scale in-phase
        start(32'h0, 16000, 0, 1'b1);
        chk("ov_start", int'(bus.out_valid), 1);
        for (int k = 0; k < 4; k++) begin
            chk("dc", dac(), 1647, 2);
            tick(1);
        end

        // fs/4 with I only, then Q only
        start(32'h4000_0000, 8000, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("fs4_i", dac(), fs4_i[k % 4], 2);
            tick(1);
        end
        start(32'h4000_0000, 0, 8000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("fs4_q", dac(), fs4_q[k % 4], 2);
            tick(1);
        end

        // fs/8 with the most negative inputs
        start(32'h2000_0000, -32768, -32768, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("fs8_neg", dac(), fs8[k % 8], 3);
            tick(1);
        end

        // Frequency sign flip loaded on edge 21
        start(32'h4000_0000, 0, 8000, 1'b1);
        tick(1);
        bus.frequency = 32'hC000_0000;
        bus.freq_load = 1'b1;
        tick(1);
        bus.freq_load = 1'b0;
        tick(14);
        for (int k = 0; k < 10; k++) begin
            chk("flip", dac(), flip[k], 2);
            tick(1);
        end

        // tx_en gating
        start(32'h0, 8000, 0, 1'b1);
        chk("tx_on", dac(), 823, 2);
        bus.tx_en = 1'b0;
        tick(19);
        for (int k = 0; k < 4; k++) begin
            chk("tx_off", dac(), 0);
            tick(1);
        end

        // 1/8-rate strobes: each value held for 8 output samples
        bus.tx_en = 1'b1;
        for (int c = 0; c < 58; c++) begin
            bus.in_valid = (c % 8 == 0) && (c < 32);
            if (c < 32)
                bus.in_I = 16'(zoh_in[c / 8]);
            tick(1);
            if (c >= 18 && c < 50 && ((c - 18) % 8 == 0 || (c - 18) % 8 == 7))
                chk("zoh", dac(), zoh_ex[(c - 18) / 8], 2);
        end
        bus.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
